lint2apb_bridge: RTL

LINT2APB_BRIDGE -- requirements
Module: lint2apb_bridge

---
 rtl/apb_bridge_pkg.sv | 21 ++
 rtl/lint2apb_bridge.sv | 133 +++++++++++++
 2 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared APB bridge definitions: FSM state encoding and the peripheral
// address window, also used by the peripheral-side decode.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    ERR
  } state_e;

  localparam logic [31:0] APB_WIN_START = 32'h1A10_0000;
  localparam logic [31:0] APB_WIN_END   = 32'h1A11_FFFF;

  // True when the (zero-extended) address falls inside the APB window.
  function automatic logic addr_in_apb_win(input logic [63:0] a);
    return (a >= {32'h0, APB_WIN_START}) && (a <= {32'h0, APB_WIN_END});
  endfunction

endpackage

// File: rtl/lint2apb_bridge.sv
// Core-side request/grant (LINT) to APB master bridge.
// One transfer outstanding at a time; out-of-window addresses and partial
// writes are rejected locally without touching the APB bus.
module lint2apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        we_i,
  input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0] be_i,
  output logic                        r_valid_o,
  output logic [APB_DATA_WIDTH-1:0]   r_rdata_o,
  output logic                        r_err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic                        pwrite,
  output logic                        psel,
  output logic                        penable,
  input  logic [APB_DATA_WIDTH-1:0]   prdata,
  input  logic                        pready,
  input  logic                        pslverr
);

  // A zero timeout keeps a 1-bit counter that never moves.
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [APB_ADDR_WIDTH-1:0]   r_addr;
  logic                        r_we;
  logic [APB_DATA_WIDTH-1:0]   r_wdata;
  logic [APB_DATA_WIDTH/8-1:0] r_be;
  logic [CNT_W-1:0]            r_cnt;
  logic                        w_accept;
  logic                        w_req_ok;
  logic                        w_timeout;

  assign gnt_o     = (r_state == IDLE) && req_i && !rst_i;
  assign w_accept  = req_i && gnt_o;
  assign w_req_ok  = addr_in_apb_win(64'(addr_i)) && (!we_i || (&be_i));
  assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

  assign paddr  = r_addr;
  assign pwdata = r_wdata;
  assign pwrite = r_we;

  // Next-state decode; pready takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_req_ok ? SETUP : ERR;
      end
      SETUP:  w_state_nxt = ACCESS;
      ACCESS: begin
        if (pready)         w_state_nxt = RESP;
        else if (w_timeout) w_state_nxt = ERR;
      end
      RESP:    w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request payload captured on acceptance and held until the next IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_addr  <= addr_i;
      r_we    <= we_i;
      r_wdata <= wdata_i;
      r_be    <= be_i;
    end
  end

  // Registered APB strobes and response, derived from the next state so
  // that they line up with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      r_valid_o <= 1'b0;
      r_err_o   <= 1'b0;
      r_rdata_o <= '0;
    end else begin
      psel      <= (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
      penable   <= (w_state_nxt == ACCESS);
      r_valid_o <= (w_state_nxt == RESP) || (w_state_nxt == ERR);
      r_err_o   <= (w_state_nxt == ERR) || ((w_state_nxt == RESP) && pslverr);
      r_rdata_o <= ((w_state_nxt == RESP) && !r_we) ? prdata : '0;
    end
  end

  // ACCESS wait-state counter for the timeout abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if ((r_state != ACCESS) && (w_state_nxt == ACCESS)) begin
      r_cnt <= '0;
    end else if (TO_EN && (r_state == ACCESS) && !pready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Only full-strobe writes may ever reach the APB bus.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (r_state == SETUP)) begin
      assert (!r_we || (&r_be));
    end
  end

endmodule
